// File: rtl/ex_muldiv_if.sv
// EX-stage multiply/divide handshake bundle: the pipeline is the master, ex_muldiv the slave.
interface ex_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             flush;
    logic             stall;
    logic             done;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    // Handshake: start is a level request sampled only in IDLE; stall stays high while the
    // request is held off, and done pulses for the single cycle in which HI/LO become valid.
    modport master (
        output start, op, A, B, flush,
        input  stall, done, HI, LO
    );

    modport slave (
        input  start, op, A, B, flush,
        output stall, done, HI, LO
    );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit for the EX stage: WIDTH shift-add / restoring-divide steps.
// Optional MULDIV_FAST_MUL_EN turns multiplies into a single-cycle IDLE->DONE operation.
module ex_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        CLR,
    ex_muldiv_if.slave  bus,
    output logic [1:0]  dbg_state
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;
    logic             op_div;
    logic             neg_res;
    logic             neg_rem;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] opnd_b;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             done_q;

    logic             take;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    assign take  = bus.start && !bus.flush;
    assign abs_a = (bus.op[0] && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    assign abs_b = (bus.op[0] && bus.B[WIDTH-1]) ? -bus.B : bus.B;

    // One multiply step: conditionally add the multiplicand into the high half, shift right.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_n;
    logic [WIDTH-1:0] mul_lo_n;
    assign mul_sum  = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_b} : {(WIDTH+1){1'b0}});
    assign mul_hi_n = mul_sum[WIDTH:1];
    assign mul_lo_n = {mul_sum[0], acc_lo[WIDTH-1:1]};

    // One restoring divide step: acc_hi is the partial remainder, acc_lo shifts dividend out
    // and quotient bits in. The remainder is always below the divisor, so WIDTH+1 bits suffice.
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_diff;
    logic [WIDTH-1:0] div_hi_n;
    logic [WIDTH-1:0] div_lo_n;
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_ge    = div_shift >= {1'b0, opnd_b};
    assign div_diff  = div_shift[WIDTH-1:0] - opnd_b;
    assign div_hi_n  = div_ge ? div_diff : div_shift[WIDTH-1:0];
    assign div_lo_n  = {acc_lo[WIDTH-2:0], div_ge};

    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;
    assign step_hi = op_div ? div_hi_n : mul_hi_n;
    assign step_lo = op_div ? div_lo_n : mul_lo_n;

    // Sign fix-up applied to the last step's output on the DONE entry edge.
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   fin_hi;
    logic [WIDTH-1:0]   fin_lo;
    always_comb begin
        prod_fix = neg_res ? -{step_hi, step_lo} : {step_hi, step_lo};
        fin_hi   = prod_fix[2*WIDTH-1:WIDTH];
        fin_lo   = prod_fix[WIDTH-1:0];
        if (op_div) begin
            if (opnd_b == '0) begin
                fin_hi = a_q;
                fin_lo = '1;
            end else begin
                fin_hi = neg_rem ? -step_hi : step_hi;
                fin_lo = neg_res ? -step_lo : step_lo;
            end
        end
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    logic [2*WIDTH-1:0] fast_prod;
    assign ext_a     = {{WIDTH{bus.op[0] & bus.A[WIDTH-1]}}, bus.A};
    assign ext_b     = {{WIDTH{bus.op[0] & bus.B[WIDTH-1]}}, bus.B};
    assign fast_prod = ext_a * ext_b;
`endif

    always_ff @(posedge clk) begin
        if (CLR) begin
            state   <= IDLE;
            count   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            op_div  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            a_q     <= '0;
            opnd_b  <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (take) begin
                        op_div  <= bus.op[1];
                        a_q     <= bus.A;
                        acc_hi  <= '0;
                        acc_lo  <= abs_a;
                        opnd_b  <= abs_b;
                        neg_res <= bus.op[0] & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                        neg_rem <= bus.op[0] & bus.A[WIDTH-1];
                        count   <= CW'(WIDTH);
                        state   <= BUSY;
`ifdef MULDIV_FAST_MUL_EN
                        if (!bus.op[1]) begin
                            hi_q   <= fast_prod[2*WIDTH-1:WIDTH];
                            lo_q   <= fast_prod[WIDTH-1:0];
                            done_q <= 1'b1;
                            count  <= '0;
                            state  <= DONE;
                        end
`endif
                    end
                end
                BUSY: begin
                    if (bus.flush) begin
                        state <= IDLE;
                        count <= '0;
                    end else begin
                        acc_hi <= step_hi;
                        acc_lo <= step_lo;
                        count  <= count - CW'(1);
                        if (count == CW'(1)) begin
                            hi_q   <= fin_hi;
                            lo_q   <= fin_lo;
                            done_q <= 1'b1;
                            state  <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.stall = ((state == IDLE) && take) || (state == BUSY);
    assign bus.done  = done_q;
    assign bus.HI    = hi_q;
    assign bus.LO    = lo_q;
    assign dbg_state = state;
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: vector table of ops plus flush, CLR and back-to-back sequences.
module tb_ex_muldiv;
    localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic       clk;
    logic       clr;
    logic [1:0] dbg_state;
    int         n_checks;
    int         n_fail;

    ex_muldiv_if #(.WIDTH(W)) bus ();
    ex_muldiv #(.WIDTH(W)) dut (
        .clk       (clk),
        .CLR       (clr),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [1:0] op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_hi;
        logic [W-1:0] exp_lo;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issues one op at a negedge and watches it to completion, sampling just after each negedge.
    task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] hi, output logic [W-1:0] lo,
                          output int stalls, output int pulses);
        bit got;
        got = 1'b0; stalls = 0; pulses = 0; hi = '0; lo = '0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.A = a; bus.B = b;
        for (int c = 0; c < 200 && !got; c++) begin
            #1;
            if (bus.stall) stalls++;
            if (bus.done) begin
                pulses++; got = 1'b1; hi = bus.HI; lo = bus.LO;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            @(negedge clk);
        end
        if (!got) check("run_op_timeout", 64'd0, 64'd1);
        for (int c = 0; c < 3; c++) begin
            #1;
            if (bus.done) pulses++;
            @(negedge clk);
        end
    endtask

    initial begin
        logic [W-1:0] hi, lo;
        int stalls, pulses, exp_stalls, t, first_t, gap;

        n_checks = 0; n_fail = 0;
        bus.start = 1'b0; bus.op = 2'b00; bus.A = '0; bus.B = '0; bus.flush = 1'b0;

        vecs[0]  = '{"multu_max",   2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{"mult_m3x7",   2'b01, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2]  = '{"div_m7d2",    2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{"divu_by0",    2'b10, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF};
        vecs[4]  = '{"div_ovf",     2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5]  = '{"multu_6x7",   2'b00, 32'd6,        32'd7,        32'd0,        32'd42};
        vecs[6]  = '{"divu_100d7",  2'b10, 32'd100,      32'd7,        32'd2,        32'd14};
        vecs[7]  = '{"div_7dm2",    2'b11, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
        vecs[8]  = '{"mult_m1xm1",  2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1};
        vecs[9]  = '{"div_m7by0",   2'b11, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[10] = '{"mult_minsq",  2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[11] = '{"divu_maxd1",  2'b10, 32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF};

        // Reset
        clr = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); clr = 1'b0;
        #1;
        check("reset_hi", 64'(bus.HI), 64'd0);
        check("reset_lo", 64'(bus.LO), 64'd0);
        check("reset_done", 64'(bus.done), 64'd0);
        check("reset_stall", 64'(bus.stall), 64'd0);
        check("reset_state", 64'(dbg_state), 64'd0);

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, hi, lo, stalls, pulses);
            exp_stalls = (FAST && !vecs[i].op[1]) ? 1 : W + 1;
            check({vecs[i].name, "_hi"}, 64'(hi), 64'(vecs[i].exp_hi));
            check({vecs[i].name, "_lo"}, 64'(lo), 64'(vecs[i].exp_lo));
            check({vecs[i].name, "_stalls"}, 64'(stalls), 64'(exp_stalls));
            check({vecs[i].name, "_pulses"}, 64'(pulses), 64'd1);
        end

        // Flush at BUSY cycle 10: prior result (100/7) must survive
        run_op(2'b10, 32'd100, 32'd7, hi, lo, stalls, pulses);
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b10; bus.A = 32'd1000; bus.B = 32'd3;
        @(posedge clk); #1; bus.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        check("flush_in_busy", 64'(dbg_state), 64'd1);
        bus.flush = 1'b1;
        @(posedge clk); #1; bus.flush = 1'b0;
        check("flush_state", 64'(dbg_state), 64'd0);
        check("flush_stall", 64'(bus.stall), 64'd0);
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        check("flush_pulses", 64'(pulses), 64'd0);
        check("flush_hi", 64'(bus.HI), 64'd2);
        check("flush_lo", 64'(bus.LO), 64'd14);

        // CLR at BUSY cycle 5
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b10; bus.A = 32'd100; bus.B = 32'd7;
        @(posedge clk); #1; bus.start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk); #1; clr = 1'b0;
        check("clr_state", 64'(dbg_state), 64'd0);
        check("clr_stall", 64'(bus.stall), 64'd0);
        check("clr_hi", 64'(bus.HI), 64'd0);
        check("clr_lo", 64'(bus.LO), 64'd0);
        pulses = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.done) pulses++;
        end
        check("clr_pulses", 64'(pulses), 64'd0);

        // Back-to-back MULTU with start held high
        @(negedge clk);
        bus.start = 1'b1; bus.op = 2'b00; bus.A = 32'h00010000; bus.B = 32'h00010003;
        pulses = 0; first_t = -1; gap = -1;
        for (t = 0; t < 120 && pulses < 2; t++) begin
            #1;
            if (bus.done) begin
                pulses++;
                if (pulses == 1) first_t = t;
                else begin
                    gap = t - first_t;
                    bus.start = 1'b0;
                    hi = bus.HI; lo = bus.LO;
                end
            end
            @(negedge clk);
        end
        check("b2b_pulses", 64'(pulses), 64'd2);
        check("b2b_gap", 64'(gap), FAST ? 64'd2 : 64'd34);
        check("b2b_hi", 64'(hi), 64'h00000001);
        check("b2b_lo", 64'(lo), 64'h00030000);
        repeat (3) @(negedge clk);
        #1;
        check("b2b_idle", 64'(dbg_state), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
